// File: rtl/ascon_perm_engine_pkg.sv
// Shared ASCON types and helpers for the self-sequencing permutation engine.
package ascon_pack;

  localparam int unsigned ROUNDS_A = 12;
  localparam int unsigned ROUNDS_B = 8;

  // S0 is element [0], S4 is element [4]
  typedef logic [4:0][63:0] type_state;

  typedef enum logic {IDLE, RUN} perm_fsm_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'(4'd15 - r), r};
  endfunction

  // Column input/output ordering is {S0,S1,S2,S3,S4} with S0 as MSB
  function automatic logic [4:0] sbox5(input logic [4:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_round.sv
// One combinational ASCON round: constant addition, S-box layer, linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  s_i,
  input  logic [3:0] round_i,
  output type_state  s_o
);

  type_state c_add;
  type_state s_box;

  always_comb begin
    c_add = s_i;
    c_add[2][7:0] = s_i[2][7:0] ^ round_const(round_i);
    s_box = '0;
    for (int unsigned b = 0; b < 64; b++) begin
      {s_box[0][b], s_box[1][b], s_box[2][b], s_box[3][b], s_box[4][b]} =
        sbox5({c_add[0][b], c_add[1][b], c_add[2][b], c_add[3][b], c_add[4][b]});
    end
  end

  assign s_o[0] = s_box[0] ^ rotr(s_box[0], 19) ^ rotr(s_box[0], 28);
  assign s_o[1] = s_box[1] ^ rotr(s_box[1], 61) ^ rotr(s_box[1], 39);
  assign s_o[2] = s_box[2] ^ rotr(s_box[2],  1) ^ rotr(s_box[2],  6);
  assign s_o[3] = s_box[3] ^ rotr(s_box[3], 10) ^ rotr(s_box[3], 17);
  assign s_o[4] = s_box[4] ^ rotr(s_box[4],  7) ^ rotr(s_box[4], 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON p^a / p^b permutation with begin/end XOR and start/done handshake.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         init_state_i,
  input  type_state    S_i,
  input  logic         xor_begin_en_i,
  input  logic [127:0] data_begin_i,
  input  logic         xor_end_en_i,
  input  logic [191:0] data_end_i,
  output logic         ready_o,
  output logic         done_o,
  output type_state    S_o,
  output logic [127:0] cipher_o,
  output logic [127:0] tag_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1, 2 or 4");
  end

  perm_fsm_t    fsm_q, fsm_d;
  type_state    state_q, state_d;
  logic [127:0] cipher_q, cipher_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         end_en_q, end_en_d;
  logic [191:0] end_data_q, end_data_d;

  type_state    stage [UNROLL+1];
  type_state    base;
  logic [4:0]   round_sum;

  assign stage[0] = state_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .s_i     (stage[g]),
      .round_i (round_q + 4'(g)),
      .s_o     (stage[g+1])
    );
  end

  assign round_sum = 5'(round_q) + 5'(UNROLL);

  // Mode is not stored separately: it is fully captured by round_q's start value.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    cipher_d   = cipher_q;
    round_d    = round_q;
    done_d     = 1'b0;
    end_en_d   = end_en_q;
    end_data_d = end_data_q;
    base       = init_state_i ? S_i : state_q;
    if (xor_begin_en_i) begin
      base[0] = base[0] ^ data_begin_i[127:64];
      base[1] = base[1] ^ data_begin_i[63:0];
    end
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d    = base;
          cipher_d   = {base[0], base[1]};
          round_d    = mode_i ? 4'(ROUNDS_A - ROUNDS_B) : 4'd0;
          end_en_d   = xor_end_en_i;
          end_data_d = data_end_i;
          fsm_d      = RUN;
        end
      end
      RUN: begin
        if (round_q >= 4'(ROUNDS_A)) begin
          fsm_d = IDLE;
        end else begin
          state_d = stage[UNROLL];
          round_d = round_sum[3:0];
          if (round_sum == 5'(ROUNDS_A)) begin
            if (end_en_q) begin
              state_d[2] = stage[UNROLL][2] ^ end_data_q[191:128];
              state_d[3] = stage[UNROLL][3] ^ end_data_q[127:64];
              state_d[4] = stage[UNROLL][4] ^ end_data_q[63:0];
            end
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      cipher_q   <= '0;
      round_q    <= '0;
      done_q     <= 1'b0;
      end_en_q   <= 1'b0;
      end_data_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      cipher_q   <= cipher_d;
      round_q    <= round_d;
      done_q     <= done_d;
      end_en_q   <= end_en_d;
      end_data_q <= end_data_d;
    end
  end

  assign ready_o  = (fsm_q == IDLE);
  assign done_o   = done_q;
  assign S_o      = state_q;
  assign cipher_o = cipher_q;
  assign tag_o    = {state_q[3], state_q[4]};

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench driving UNROLL=1/2/4 engines in parallel against a bitsliced reference model.
module tb_ascon_perm_engine;
  import ascon_pack::*;

  localparam int unsigned UNR [3] = '{1, 2, 4};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         init = 1'b0;
  type_state    s_in = '0;
  logic         xb_en = 1'b0;
  logic [127:0] db = '0;
  logic         xe_en = 1'b0;
  logic [191:0] de = '0;

  logic [2:0]   ready;
  logic [2:0]   done;
  type_state    s_out [3];
  logic [127:0] cipher [3];
  logic [127:0] tag [3];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    type_state    st;
    logic [127:0] ciph;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t      q0[$], q1[$], q2[$];
  type_state m_st [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_perm_engine #(.UNROLL(1)) u_u1 (
    .clock_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .init_state_i(init),
    .S_i(s_in), .xor_begin_en_i(xb_en), .data_begin_i(db), .xor_end_en_i(xe_en),
    .data_end_i(de), .ready_o(ready[0]), .done_o(done[0]), .S_o(s_out[0]),
    .cipher_o(cipher[0]), .tag_o(tag[0]));

  ascon_perm_engine #(.UNROLL(2)) u_u2 (
    .clock_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .init_state_i(init),
    .S_i(s_in), .xor_begin_en_i(xb_en), .data_begin_i(db), .xor_end_en_i(xe_en),
    .data_end_i(de), .ready_o(ready[1]), .done_o(done[1]), .S_o(s_out[1]),
    .cipher_o(cipher[1]), .tag_o(tag[1]));

  ascon_perm_engine #(.UNROLL(4)) u_u4 (
    .clock_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .init_state_i(init),
    .S_i(s_in), .xor_begin_en_i(xb_en), .data_begin_i(db), .xor_end_en_i(xe_en),
    .data_end_i(de), .ready_o(ready[2]), .done_o(done[2]), .S_o(s_out[2]),
    .cipher_o(cipher[2]), .tag_o(tag[2]));

  task automatic chk(input string tag_s, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag_s, act, exp);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state model_perm(input type_state s, input int first);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    for (int rnd = first; rnd < 12; rnd++) begin
      x2 = x2 ^ 64'((15 - rnd) * 16 + rnd);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
      x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    end
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  task automatic model_start(input int k, input int scyc);
    exp_t e;
    type_state b;
    b = init ? s_in : m_st[k];
    if (xb_en) begin
      b[0] = b[0] ^ db[127:64];
      b[1] = b[1] ^ db[63:0];
    end
    e.ciph = {b[0], b[1]};
    e.st = model_perm(b, mode ? 4 : 0);
    if (xe_en) begin
      e.st[2] = e.st[2] ^ de[191:128];
      e.st[3] = e.st[3] ^ de[127:64];
      e.st[4] = e.st[4] ^ de[63:0];
    end
    m_st[k] = e.st;
    e.start_cyc = scyc;
    e.lat = (mode ? 8 : 12) / int'(UNR[k]);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    bit got = 0;
    case (k)
      0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1; end
    endcase
    if (!got) begin
      chk($sformatf("spurious_done_u%0d", UNR[k]), 1, 0);
    end else begin
      chk($sformatf("state_u%0d", UNR[k]), s_out[k], e.st);
      chk($sformatf("tag_u%0d", UNR[k]), tag[k], {e.st[3], e.st[4]});
      chk($sformatf("cipher_u%0d", UNR[k]), cipher[k], e.ciph);
      chk($sformatf("latency_u%0d", UNR[k]), cyc - e.start_cyc, e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) if (done[k]) pop_check(k);
    end
  end

  function automatic int pending();
    return q0.size() + q1.size() + q2.size();
  endfunction

  task automatic flush_all();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic wait_all();
    int n = 0;
    while (pending() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (pending() != 0) begin
      chk("done_timeout", pending(), 0);
      flush_all();
    end
  endtask

  // Caller sets the data inputs; this issues a one-edge start to all three engines.
  task automatic start_all();
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) model_start(k, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  type_state iv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
    $fatal(1);
  end

  initial begin
    iv[0] = 64'h00001000808C0001;
    iv[1] = 64'h6CB10AD9CA912F80;
    iv[2] = 64'h691AED630E81901F;
    iv[3] = 64'h0C4C36A20853217C;
    iv[4] = 64'h46487B3E06D9D7A8;
    for (int k = 0; k < 3; k++) m_st[k] = '0;

    // Power-on reset state
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 3'b111);
    chk("reset_done", done, 3'b000);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_state_u%0d", UNR[k]), s_out[k], '0);
      chk($sformatf("reset_cipher_u%0d", UNR[k]), cipher[k], '0);
    end
    rst_n = 1'b1;

    // Reset mid-run at round 5 of the UNROLL=1 engine
    init = 1'b1; s_in = iv; mode = 1'b0; xb_en = 1'b0; xe_en = 1'b0;
    start_all();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_u4_finished", q2.size(), 0);
    chk("abort_ready", ready, 3'b111);
    chk("abort_done", done, 3'b000);
    chk("abort_state_u1", s_out[0], '0);
    chk("abort_state_u2", s_out[1], '0);
    flush_all();
    for (int k = 0; k < 3; k++) m_st[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Initialisation p^a with key XORed in at the end
    init = 1'b1; s_in = iv; mode = 1'b0; xb_en = 1'b0;
    xe_en = 1'b1; de = {64'h0, 128'h000102030405060708090A0B0C0D0E0F};
    start_all();
    wait_all();

    // p^b with begin XOR on the chained state
    init = 1'b0; mode = 1'b1; xb_en = 1'b1; xe_en = 1'b0;
    db = 128'h00112233445566778899AABBCCDDEEFF;
    start_all();
    wait_all();

    // Back-to-back: start held high for 10 edges
    begin
      int c0;
      int per;
      init = 1'b0; mode = 1'b1; xb_en = 1'b1; xe_en = 1'b1;
      db = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0; de = {3{64'h0123456789ABCDEF}};
      @(negedge clk);
      c0 = cyc;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
        per = 8 / int'(UNR[k]) + 1;
        for (int off = 0; off < 10; off += per) model_start(k, c0 + 1 + off);
      end
      repeat (10) @(negedge clk);
      start = 1'b0;
      wait_all();
    end

    // Inputs disturbed during RUN must not affect the running permutation
    init = 1'b1; s_in = iv; mode = 1'b0; xb_en = 1'b0;
    xe_en = 1'b1; de = {64'h0, 128'hFFEEDDCCBBAA99887766554433221100};
    start_all();
    start = 1'b1; mode = 1'b1; de = ~de; xe_en = 1'b0; s_in = '1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_all();

    // Random runs across all three UNROLL settings
    for (int i = 0; i < 1000; i++) begin
      init = 1'($urandom_range(0, 3) == 0);
      mode = 1'($urandom);
      xb_en = 1'($urandom);
      xe_en = 1'($urandom);
      for (int w = 0; w < 5; w++) s_in[w] = {$urandom, $urandom};
      db = {$urandom, $urandom, $urandom, $urandom};
      de = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start_all();
      wait_all();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
